hazard_forward_ctrl: RTL

- Parametrised next-generation hazard and forwarding controller for the 5-stage pipeline.
- Generalises forwarding to NUM_SRC source operands of REG_AW-bit register indices, with EX/MEM over MEM/WB priority.
- Adds a sequential stall engine: a multi-cycle load-use stall (LOAD_USE_CYC) and a data-memory wait freeze with a timeout flag.
- Adds a saturating stall-cycle counter.
- Sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and the PC/IF/ID enables.

---
 rtl/hazard_forward_ctrl_if.sv | 39 +++
 rtl/hazard_forward_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl_if.sv
// Bundle between the pipeline registers and the hazard/forwarding controller.
// master = pipeline side, slave = controller side.
interface hazard_forward_ctrl_if #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
);
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC*REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_regwrite;
    logic                      ex_memread;
    logic [REG_AW-1:0]         mem_rd;
    logic                      mem_regwrite;
    logic                      mem_req;
    logic                      mem_ready;
    logic [REG_AW-1:0]         wb_rd;
    logic                      wb_regwrite;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall_if;
    logic                      stall_id;
    logic                      flush_ex;
    logic                      freeze;
    logic                      mem_timeout;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output id_valid, id_rs, ex_rs, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_req, mem_ready, wb_rd, wb_regwrite,
        input  fwd_sel, stall_if, stall_id, flush_ex, freeze, mem_timeout, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, ex_rs, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_req, mem_ready, wb_rd, wb_regwrite,
        output fwd_sel, stall_if, stall_id, flush_ex, freeze, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller: per-source forwarding, load-use stall and memory-wait freeze.
// Optional WB-bypass (select 11) enabled by defining HFC_WB_BYPASS_EN.
module hazard_forward_ctrl #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned LOAD_USE_CYC = 1,
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_forward_ctrl_if.slave  io_bus
);
    localparam int unsigned LU_W   = $clog2(LOAD_USE_CYC) + 1;
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {StRun, StLu, StWait} state_e;

    state_e               r_state, w_state_d;
    state_e               r_ret, w_ret_d;
    logic [LU_W-1:0]      r_lu_cnt, w_lu_cnt_d;
    logic [WAIT_W-1:0]    r_wait_cnt, w_wait_cnt_d;
    logic                 r_mem_timeout, w_mem_timeout_d;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [NUM_SRC*2-1:0] w_fwd_sel;
    logic                 w_lu_hit, w_lu, w_mem_busy, w_waiting;
    logic                 w_stall, w_flush, w_freeze;

`ifdef HFC_WB_BYPASS_EN
    logic [REG_AW-1:0]    r_wbx_rd;
    logic                 r_wbx_we;

    // Last-written WB destination, held while the pipeline is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbx_rd <= '0;
            r_wbx_we <= 1'b0;
        end else if (!w_freeze) begin
            r_wbx_rd <= io_bus.wb_rd;
            r_wbx_we <= io_bus.wb_regwrite;
        end
    end
`endif

    always_comb begin
        w_fwd_sel = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (io_bus.mem_regwrite && (io_bus.mem_rd != '0) &&
                (io_bus.mem_rd == io_bus.ex_rs[i*REG_AW +: REG_AW])) begin
                w_fwd_sel[2*i +: 2] = 2'b10;
            end else if (io_bus.wb_regwrite && (io_bus.wb_rd != '0) &&
                         (io_bus.wb_rd == io_bus.ex_rs[i*REG_AW +: REG_AW])) begin
                w_fwd_sel[2*i +: 2] = 2'b01;
`ifdef HFC_WB_BYPASS_EN
            end else if (r_wbx_we && (r_wbx_rd != '0) &&
                         (r_wbx_rd == io_bus.ex_rs[i*REG_AW +: REG_AW])) begin
                w_fwd_sel[2*i +: 2] = 2'b11;
`endif
            end
        end
    end

    always_comb begin
        w_lu_hit = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (io_bus.id_rs[i*REG_AW +: REG_AW] == io_bus.ex_rd) w_lu_hit = 1'b1;
        end
    end

    assign w_lu = io_bus.id_valid & io_bus.ex_memread & io_bus.ex_regwrite &
                  (io_bus.ex_rd != '0) & w_lu_hit;
    assign w_mem_busy = io_bus.mem_req & ~io_bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StRun;
            r_ret         <= StRun;
            r_lu_cnt      <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_ret         <= w_ret_d;
            r_lu_cnt      <= w_lu_cnt_d;
            r_wait_cnt    <= w_wait_cnt_d;
            r_mem_timeout <= w_mem_timeout_d;
        end
    end

    // wait_cnt counts waiting cycles including the one that entered WAIT.
    always_comb begin
        w_state_d    = r_state;
        w_ret_d      = r_ret;
        w_lu_cnt_d   = r_lu_cnt;
        w_wait_cnt_d = r_wait_cnt;
        case (r_state)
            StRun: begin
                if (w_mem_busy) begin
                    w_state_d    = StWait;
                    w_ret_d      = StRun;
                    w_wait_cnt_d = WAIT_W'(1);
                end else if (w_lu && (LOAD_USE_CYC > 1)) begin
                    w_state_d  = StLu;
                    w_lu_cnt_d = LU_W'(LOAD_USE_CYC - 1);
                end
            end
            StLu: begin
                if (w_mem_busy) begin
                    w_state_d    = StWait;
                    w_ret_d      = StLu;
                    w_wait_cnt_d = WAIT_W'(1);
                end else begin
                    w_lu_cnt_d = r_lu_cnt - 1'b1;
                    if (r_lu_cnt == LU_W'(1)) w_state_d = StRun;
                end
            end
            StWait: begin
                if (io_bus.mem_ready) begin
                    w_state_d    = r_ret;
                    w_wait_cnt_d = '0;
                end else if (r_wait_cnt != '1) begin
                    w_wait_cnt_d = r_wait_cnt + 1'b1;
                end
            end
            default: w_state_d = StRun;
        endcase
    end

    assign w_waiting = (r_state == StWait) ? ~io_bus.mem_ready : w_mem_busy;
    assign w_mem_timeout_d = r_mem_timeout |
                             (w_waiting & (w_wait_cnt_d >= WAIT_W'(MEM_TIMEOUT - 1)));

    always_comb begin
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        w_freeze = 1'b0;
        case (r_state)
            StRun: begin
                if (w_mem_busy) begin
                    w_stall  = 1'b1;
                    w_freeze = 1'b1;
                end else if (w_lu) begin
                    w_stall = 1'b1;
                    w_flush = 1'b1;
                end
            end
            StLu: begin
                w_stall  = 1'b1;
                w_freeze = w_mem_busy;
                w_flush  = ~w_mem_busy;
            end
            StWait: begin
                w_stall  = 1'b1;
                w_freeze = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign io_bus.fwd_sel     = w_fwd_sel;
    assign io_bus.stall_if    = w_stall;
    assign io_bus.stall_id    = w_stall;
    assign io_bus.flush_ex    = w_flush;
    assign io_bus.freeze      = w_freeze;
    assign io_bus.mem_timeout = r_mem_timeout;
    assign io_bus.stall_cnt   = r_stall_cnt;
endmodule
